// File: rtl/countdown_timer_core.sv
// countdown_timer_core
//   MM:SS countdown timer with BCD digit outputs. The user tunes the value
//   one field at a time, then start/pause toggles a 1 Hz countdown that ends
//   in DONE at 00:00.
//
//   Parameter
//     MAX_MINUTES      highest minutes value (1..99); tuning wraps it to 00
//
//   Ports
//     clock            system clock, rising edge
//     resetn           asynchronous active-low reset
//     increment_signal one-cycle pulse, +1 on the selected field (TUNE only)
//     tunning          level, 1 = tuning mode (highest priority)
//     field_sel        0 = seconds, 1 = minutes
//     start_pulse      one-cycle start/pause toggle
//     tick_1hz         one-cycle pulse per second (RUN only)
//     min_tens..sec_ones  registered BCD digits of MM:SS
//     running          registered, high in RUN
//     done             registered, high in DONE
//
//   Build option
//     TIMER_AUTO_RELOAD_EN  defined: DONE lasts one cycle, then the value
//                           reloads from the preset captured when tuning
//                           ended and the block returns to IDLE.
//                           undefined: DONE holds at 00:00 until tunning=1.
//
//   state | meaning
//   IDLE  | holding a value, waiting for start_pulse
//   TUNE  | user edits minutes/seconds with increment_signal
//   RUN   | counting down one second per tick_1hz
//   DONE  | count reached 00:00
module countdown_timer_core #(
    parameter int unsigned MAX_MINUTES = 59
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       increment_signal,
    input  logic       tunning,
    input  logic       field_sel,
    input  logic       start_pulse,
    input  logic       tick_1hz,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TUNE = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] MAX_MT = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MAX_MO = 4'(MAX_MINUTES % 10);

    // digits packed as {min_tens, min_ones, sec_tens, sec_ones}
    state_t      state_q, state_d;
    logic [15:0] digits_q, digits_d;
    logic        running_q, done_q;
`ifdef TIMER_AUTO_RELOAD_EN
    logic [15:0] preset_q, preset_d;
`endif

    logic [7:0]  sec_inc;
    logic [7:0]  min_inc;
    logic [15:0] dec_val;

    always_comb begin
        if (digits_q[7:0] == 8'h59)
            sec_inc = 8'h00;
        else if (digits_q[3:0] == 4'd9)
            sec_inc = {digits_q[7:4] + 4'd1, 4'd0};
        else
            sec_inc = {digits_q[7:4], digits_q[3:0] + 4'd1};

        if (digits_q[15:8] == {MAX_MT, MAX_MO})
            min_inc = 8'h00;
        else if (digits_q[11:8] == 4'd9)
            min_inc = {digits_q[15:12] + 4'd1, 4'd0};
        else
            min_inc = {digits_q[15:12], digits_q[11:8] + 4'd1};

        // BCD decrement with borrow; only used when the value is non-zero,
        // so the minutes-tens guard never actually triggers.
        dec_val = digits_q;
        if (digits_q[3:0] != 4'd0) begin
            dec_val[3:0] = digits_q[3:0] - 4'd1;
        end else begin
            dec_val[3:0] = 4'd9;
            if (digits_q[7:4] != 4'd0) begin
                dec_val[7:4] = digits_q[7:4] - 4'd1;
            end else begin
                dec_val[7:4] = 4'd5;
                if (digits_q[11:8] != 4'd0) begin
                    dec_val[11:8] = digits_q[11:8] - 4'd1;
                end else begin
                    dec_val[11:8] = 4'd9;
                    if (digits_q[15:12] != 4'd0)
                        dec_val[15:12] = digits_q[15:12] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
`ifdef TIMER_AUTO_RELOAD_EN
        preset_d = preset_q;
`endif
        if (tunning) begin
            state_d = S_TUNE;
            // only count pulses once we are already tuning
            if (state_q == S_TUNE && increment_signal) begin
                if (field_sel)
                    digits_d[15:8] = min_inc;
                else
                    digits_d[7:0] = sec_inc;
            end
        end else begin
            case (state_q)
                S_TUNE: begin
                    state_d = S_IDLE;
`ifdef TIMER_AUTO_RELOAD_EN
                    preset_d = digits_q;
`endif
                end
                S_IDLE: begin
                    if (start_pulse && digits_q != 16'h0000)
                        state_d = S_RUN;
                end
                S_RUN: begin
                    // pause beats a coincident tick
                    if (start_pulse) begin
                        state_d = S_IDLE;
                    end else if (tick_1hz) begin
                        digits_d = dec_val;
                        if (dec_val == 16'h0000)
                            state_d = S_DONE;
                    end
                end
                S_DONE: begin
`ifdef TIMER_AUTO_RELOAD_EN
                    state_d  = S_IDLE;
                    digits_d = preset_q;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            digits_q  <= 16'h0000;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
            preset_q  <= 16'h0000;
`endif
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
`ifdef TIMER_AUTO_RELOAD_EN
            preset_q  <= preset_d;
`endif
        end
    end

    assign min_tens = digits_q[15:12];
    assign min_ones = digits_q[11:8];
    assign sec_tens = digits_q[7:4];
    assign sec_ones = digits_q[3:0];
    assign running  = running_q;
    assign done     = done_q;

endmodule

// File: doc/countdown_timer_core.md
COUNTDOWN_TIMER_CORE -- requirements
Module: countdown_timer_core

Interface
REQ-001 Parameter: MAX_MINUTES, default 59, upper bound of the minutes field (range 1..99); the value wraps to 00 above it.
REQ-002 The block SHALL have the following ports:
  clock  input  1  single system clock, rising edge.
  resetn  input  1  asynchronous, active-low reset.
  increment_signal  input  1  one-cycle pulse from the button edge stage; adds one to the selected field.
  tunning  input  1  level; 1 = tuning mode.
  field_sel  input  1  0 = seconds field, 1 = minutes field.
  start_pulse  input  1  one-cycle pulse; start/pause toggle.
  tick_1hz  input  1  one-cycle pulse, once per second.
  min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD digits of the current MM:SS value, registered.
  running  output  1  high in RUN.
  done  output  1  high in DONE.

Function
REQ-003 The block SHALL implement four states: IDLE, TUNE, RUN, DONE.
REQ-004 tunning=1 SHALL force TUNE on the next edge from any state, with priority over all other inputs.
REQ-005 TUNE, increment_signal=1: the block SHALL add one to the field selected by field_sel, with the digits registered on the same edge.
  - Seconds: 59 wraps to 00, with no carry into minutes.
  - Minutes: MAX_MINUTES wraps to 00.
REQ-006 TUNE with tunning=0: the block SHALL go to IDLE and capture the current MM:SS into an internal preset register.
REQ-007 IDLE, start_pulse=1:
  - Value non-zero: the block SHALL go to RUN.
  - Value 00:00: the block SHALL stay in IDLE.
REQ-008 RUN, tick_1hz=1: the block SHALL decrement the value by one second in BCD, with borrow.
  - sec_ones 0 becomes 9, borrowing from sec_tens.
  - Seconds 00 becomes 59, borrowing one minute.
REQ-009 RUN: when a decrement produces 00:00, the block SHALL enter DONE on that same edge.
REQ-010 RUN, start_pulse=1: the block SHALL pause to IDLE and hold the value.
  - If tick_1hz coincides, the pause wins and no decrement occurs.
REQ-011 The block SHALL ignore increment_signal outside TUNE and tick_1hz outside RUN.
REQ-012 DONE SHALL ignore start_pulse; it exits only via tunning or per REQ-017.
REQ-013 running and done SHALL be registered, mutually exclusive, and change on the same edge as the state.
REQ-014 All digit outputs SHALL always hold legal BCD values (0-9, with tens of seconds at most 5).

Reset
REQ-015 On resetn=0, asynchronously, the block SHALL set:
  - state = IDLE;
  - all digits = 0;
  - preset = 00:00;
  - running = 0, done = 0.
REQ-016 Reset asserted during RUN SHALL abandon the count with no done pulse; after release the block SHALL wait in IDLE at 00:00.

Configuration
REQ-017 Macro TIMER_AUTO_RELOAD_EN.
  - Defined: DONE SHALL last exactly one cycle (done is a one-cycle pulse), then the value reloads from preset and the state returns to IDLE.
  - Undefined: DONE SHALL hold at 00:00 with done=1 until tunning=1.

Verification
REQ-018 Reset, then tunning=1, field_sel=0, and 61 increment_signal pulses -> digits read 00:01 (wrap at 59, no carry).
REQ-019 Tune 01:00, tunning=0, start_pulse, then one tick_1hz -> 00:59, running=1.
REQ-020 In RUN at 00:01, one tick_1hz -> 00:00, done=1, running=0 on the same edge.
  - Without the macro: done stays high.
  - With the macro: done drops after 1 cycle and the digits return to the preset value.
REQ-021 In RUN at 00:10, start_pulse and tick_1hz on the same cycle -> IDLE, value stays 00:10, running=0.
REQ-022 resetn pulsed low mid-RUN at 00:30 -> all digits 0 immediately, done never asserted; start_pulse afterwards -> remains IDLE.
REQ-023 Minutes tuning with MAX_MINUTES=59: 60 pulses starting from 00 -> minutes read 00.
